// File: rtl/cskipa_accum_41bit_if.sv
// Handshake and data bundle for the streaming carry-skip accumulator.
// The master side drives job requests, operands and result acceptance.
// The slave side is the accumulator, which returns readiness, results and status.
interface cskipa_accum_41bit_if #(
    parameter int WIDTH = 41,
    parameter int CNT_W = 8
);

    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_ovf;
    logic [CNT_W-1:0] o_count;
    logic             o_busy;

    modport master (
        output i_start,
        output i_len,
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_sum,
        input  o_ovf,
        input  o_count,
        input  o_busy
    );

    modport slave (
        input  i_start,
        input  i_len,
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_sum,
        output o_ovf,
        output o_count,
        output o_busy
    );

endinterface

// File: rtl/cskipa_accum_41bit.sv
// Streaming accumulator built around a combinational carry-skip adder.
// A job sums i_len operands modulo 2^WIDTH and records any carry out as a
// sticky overflow, then offers the total on a valid/ready result port.

// Carry-skip adder: bits ripple inside fixed-size blocks, and a block whose
// bits all propagate passes its incoming carry straight to the next block.
// The final block may be narrower than BLK when WIDTH is not a multiple.
module CSkipA_41bit #(
    parameter int WIDTH = 41,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic carry;
    logic blkIn;
    logic blkProp;
    logic bitProp;

    // Ripple within each block, then choose between the rippled carry and the skip path at the block boundary.
    always_comb begin
        sum_o   = '0;
        carry   = cin_i;
        blkIn   = cin_i;
        blkProp = 1'b1;
        bitProp = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            bitProp  = a_i[i] ^ b_i[i];
            sum_o[i] = bitProp ^ carry;
            carry    = (a_i[i] & b_i[i]) | (bitProp & carry);
            blkProp  = blkProp & bitProp;
            if (((i % BLK) == (BLK - 1)) || (i == (WIDTH - 1))) begin
                carry   = blkProp ? blkIn : carry;
                blkIn   = carry;
                blkProp = 1'b1;
            end
        end
        cout_o = carry;
    end

endmodule

// Accumulator controller: IDLE waits for a start, ACC folds each accepted
// operand into the running sum, DONE holds the result until it is taken.
module cskipa_accum_41bit #(
    parameter int WIDTH = 41,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    cskipa_accum_41bit_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;

    logic [WIDTH-1:0] addSum;
    logic             addCout;
    logic             beatAccept;

    // The adder always sees the running total and the current operand; its result only matters on an accepted beat.
    CSkipA_41bit #(
        .WIDTH (WIDTH),
        .BLK   (4)
    ) uAdder (
        .a_i    (acc_q),
        .b_i    (bus.i_data),
        .cin_i  (1'b0),
        .sum_o  (addSum),
        .cout_o (addCout)
    );

    assign beatAccept = (state_q == ACC) && bus.i_valid;

    // State and datapath registers; reset wins over any job in flight and discards it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state logic; starts outside IDLE are ignored and the result registers are kept after hand-off.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    count_d     = '0;
                    remaining_d = bus.i_len;
                    state_d     = (bus.i_len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (beatAccept) begin
                    acc_d       = addSum;
                    ovf_d       = ovf_q | addCout;
                    count_d     = count_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs follow the state directly; result fields mirror the registers at all times.
    always_comb begin
        bus.o_ready = (state_q == ACC);
        bus.o_valid = (state_q == DONE);
        bus.o_busy  = (state_q == ACC) || (state_q == DONE);
        bus.o_sum   = acc_q;
        bus.o_ovf   = ovf_q;
        bus.o_count = count_q;
    end

endmodule
